// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: valid/ready sample load, one bit out per en_i strobe.
// Define PISO_PRESET_EN to add the synchronous all-ones preset input prst_i.
module piso_serializer #(
  parameter int WIDTH     = 24,
  parameter bit LSB_FIRST = 1'b0,
  parameter bit IDLE_LVL  = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic                       load_valid_i,
  input  logic [WIDTH-1:0]           load_data_i,
  output logic                       load_ready_o,
`ifdef PISO_PRESET_EN
  input  logic                       prst_i,
`endif
  output logic                       sdo_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [$clog2(WIDTH+1)-1:0] count_o
);

  // state    | meaning
  // ST_IDLE  | no word in flight, sdo_o at IDLE_LVL, ready for a load
  // ST_SHIFT | word in flight, one bit consumed per en_i strobe

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  logic             preset;
  logic             last_bit;
  logic             ready;
  logic             accept;
  logic [WIDTH-1:0] shifted;

`ifdef PISO_PRESET_EN
  assign preset = prst_i;
`else
  assign preset = 1'b0;
`endif

  // The final strobe of a word opens the ready window so the next word can follow gaplessly.
  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == CW'(1)) && en_i;
  assign ready    = ((state_q == ST_IDLE) || last_bit) && !preset;
  assign accept   = load_valid_i && ready;
  assign shifted  = LSB_FIRST ? {1'b0, shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], 1'b0};

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = last_bit && !preset;
    if (preset) begin
      state_d = ST_SHIFT;
      shreg_d = '1;
      cnt_d   = CW'(WIDTH);
    end else if (accept) begin
      state_d = ST_SHIFT;
      shreg_d = load_data_i;
      cnt_d   = CW'(WIDTH);
    end else if ((state_q == ST_SHIFT) && en_i) begin
      shreg_d = shifted;
      cnt_d   = cnt_q - CW'(1);
      if (last_bit) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign load_ready_o = ready;
  assign busy_o       = (state_q == ST_SHIFT);
  assign done_o       = done_q;
  assign count_o      = cnt_q;
  assign sdo_o        = (state_q == ST_SHIFT) ? (LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1])
                                              : IDLE_LVL;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first/idle-low and LSB-first/idle-high instances share stimulus,
// each checked against a queue-of-bits reference model.
module tb_piso_serializer;
  localparam int W  = 8;
  localparam int CW = $clog2(W+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          lv  = 1'b0;
  logic [W-1:0]  ld  = '0;
  logic          prst = 1'b0;

  logic          rdy_a, sdo_a, busy_a, done_a;
  logic [CW-1:0] cnt_a;
  logic          rdy_b, sdo_b, busy_b, done_b;
  logic [CW-1:0] cnt_b;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_LVL(1'b0)) u_msb (
    .clk_i(clk), .rst_i(rst), .en_i(en), .load_valid_i(lv), .load_data_i(ld),
    .load_ready_o(rdy_a),
`ifdef PISO_PRESET_EN
    .prst_i(prst),
`endif
    .sdo_o(sdo_a), .busy_o(busy_a), .done_o(done_a), .count_o(cnt_a)
  );

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_LVL(1'b1)) u_lsb (
    .clk_i(clk), .rst_i(rst), .en_i(en), .load_valid_i(lv), .load_data_i(ld),
    .load_ready_o(rdy_b),
`ifdef PISO_PRESET_EN
    .prst_i(prst),
`endif
    .sdo_o(sdo_b), .busy_o(busy_b), .done_o(done_b), .count_o(cnt_b)
  );

  // Reference model: remaining bits of the word in flight, in transmit order.
  bit qa[$];
  bit qb[$];
  bit done_exp = 1'b0;
  int n_chk  = 0;
  int n_fail = 0;

  function automatic bit model_ready();
    return ((qa.size() == 0) || ((qa.size() == 1) && en)) && !prst;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qa.delete();
      qb.delete();
      done_exp = 1'b0;
    end else begin
      bit acc;
      acc      = lv && model_ready();
      done_exp = en && (qa.size() == 1) && !prst;
      if (prst) begin
        qa.delete();
        qb.delete();
        for (int i = 0; i < W; i++) begin
          qa.push_back(1'b1);
          qb.push_back(1'b1);
        end
      end else begin
        if (en && (qa.size() != 0)) begin
          void'(qa.pop_front());
          void'(qb.pop_front());
        end
        if (acc) begin
          for (int i = 0; i < W; i++) begin
            qa.push_back(ld[W-1-i]);
            qb.push_back(ld[i]);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("ready_msb", 32'(rdy_a), 32'(model_ready()));
    chk("ready_lsb", 32'(rdy_b), 32'(model_ready()));
    chk("sdo_msb", 32'(sdo_a), 32'((qa.size() != 0) ? qa[0] : 1'b0));
    chk("sdo_lsb", 32'(sdo_b), 32'((qb.size() != 0) ? qb[0] : 1'b1));
    chk("busy_msb", 32'(busy_a), 32'(qa.size() != 0));
    chk("busy_lsb", 32'(busy_b), 32'(qb.size() != 0));
    chk("count_msb", 32'(cnt_a), 32'(qa.size()));
    chk("count_lsb", 32'(cnt_b), 32'(qb.size()));
    chk("done_msb", 32'(done_a), 32'(done_exp));
    chk("done_lsb", 32'(done_b), 32'(done_exp));
  end

  // Upstream holds an offered word until it sees ready just before the edge.
  bit           pend   = 1'b0;
  logic [W-1:0] pend_d = '0;

  task automatic offer(input logic [W-1:0] d);
    pend   = 1'b1;
    pend_d = d;
  endtask

  task automatic tick(input bit e);
    en = e;
    lv = pend;
    ld = pend_d;
    #8;
    if (pend && rdy_a) pend = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((pend || (qa.size() != 0)) && (k < budget)) begin
      tick(1'b1);
      k++;
    end
    n_chk++;
    if (pend || (qa.size() != 0)) begin
      n_fail++;
      $display("FAIL drain_timeout: pending=%0d remaining=%0d required 0", pend, qa.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Load offered during reset must be ignored.
    lv = 1'b1;
    ld = 8'h5A;
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    lv  = 1'b0;
    en  = 1'b0;
    rst = 1'b0;
    tick(1'b0);
    tick(1'b1);

    // MSB-first word with continuous strobe.
    offer(8'hA5);
    tick(1'b0);
    repeat (8) tick(1'b1);
    repeat (3) tick(1'b0);

    // Strobe every third cycle.
    offer(8'h0F);
    tick(1'b0);
    for (int k = 0; k < 24; k++) tick(k % 3 == 2);
    repeat (3) tick(1'b0);

    // Back-to-back words.
    offer(8'hFF);
    tick(1'b0);
    offer(8'h00);
    repeat (16) tick(1'b1);
    repeat (3) tick(1'b0);

    // Stall while busy, next word taken on the final strobe.
    offer(8'hA5);
    tick(1'b0);
    repeat (3) tick(1'b1);
    offer(8'h3C);
    repeat (2) tick(1'b0);
    repeat (13) tick(1'b1);
    repeat (2) tick(1'b0);

    // Reset mid-word, then a fresh word.
    offer(8'hC3);
    tick(1'b0);
    repeat (4) tick(1'b1);
    rst = 1'b1;
    tick(1'b1);
    rst = 1'b0;
    tick(1'b0);
    offer(8'h81);
    tick(1'b0);
    repeat (8) tick(1'b1);
    repeat (2) tick(1'b0);

`ifdef PISO_PRESET_EN
    // Preset mid-word with a load offered at the same time.
    offer(8'hA5);
    tick(1'b0);
    repeat (3) tick(1'b1);
    offer(8'h00);
    prst = 1'b1;
    tick(1'b1);
    prst = 1'b0;
    drain(40);
    repeat (2) tick(1'b0);
`endif

    // Randomized traffic with varying strobe density and occasional resets.
    for (int blk = 0; blk < 6; blk++) begin
      int pct;
      pct = (blk == 0) ? 100 : $urandom_range(20, 100);
      for (int k = 0; k < 500; k++) begin
        if (!pend && ($urandom_range(0, 2) == 0)) offer(W'($urandom));
        if ($urandom_range(0, 399) == 0) rst = 1'b1;
`ifdef PISO_PRESET_EN
        if ($urandom_range(0, 199) == 0) prst = 1'b1;
`endif
        tick($urandom_range(1, 100) <= pct);
        rst  = 1'b0;
        prst = 1'b0;
      end
    end
    drain(100);
    repeat (2) tick(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out serializer for the WM8131 audio path. It accepts a WIDTH-bit sample through a valid/ready load handshake and shifts it out one bit per `en_i` strobe (bit-clock enable), MSB- or LSB-first. It supports gapless back-to-back words and flags completion of each word. It replaces the per-bit flip-flop chain in the PISO stage with a single generic block.

## Interface
Parameters:
- `WIDTH`, default 24: sample width in bits; legal range is WIDTH ≥ 2.
- `LSB_FIRST`, default 0: 0 shifts out MSB first; 1 shifts out LSB first.
- `IDLE_LVL`, default 0: level driven on `sdo_o` when no word is in flight.

Ports (CW = $clog2(WIDTH+1)):
- `clk_i`  in  1: clock. Single clock domain.
- `rst_i`  in  1: reset, asynchronous, active-high.
- `en_i`  in  1: shift strobe. One serial bit is consumed per cycle in which it is high.
- `load_valid_i`  in  1: a new sample is offered.
- `load_data_i`  in  WIDTH: the sample offered.
- `load_ready_o`  out  1: the block can accept a sample this cycle.
- `prst_i`  in  1: synchronous preset. Present only with `PISO_PRESET_EN`.
- `sdo_o`  out  1: serial data out.
- `busy_o`  out  1: a word is in flight.
- `done_o`  out  1: one-cycle pulse after the last bit of a word is consumed.
- `count_o`  out  CW: number of bits of the current word not yet consumed.

## Operation
State machine with two states, IDLE and SHIFT.
- **Reset:** state=IDLE, shift register=0, count=0, `done_o`=0, `busy_o`=0, `sdo_o`=IDLE_LVL, `load_ready_o`=1. A load offered while `rst_i` is high is ignored.
- **IDLE:**
  - `load_ready_o`=1.
  - On accept (`load_valid_i` & `load_ready_o`): capture `load_data_i`, set count=WIDTH, go to SHIFT.
  - `en_i` has no effect in IDLE.
- **SHIFT:**
  - `sdo_o` = current bit: bit WIDTH-1 of the register, or bit 0 when LSB_FIRST=1.
  - On `en_i`: shift the register by one toward the output end, zero-filling; count decrements by 1.
- **Last bit (count==1 and `en_i`):**
  - Register `done_o`=1 for the next cycle.
  - If a load is accepted in the same cycle, capture the new word, set count=WIDTH and stay in SHIFT. This is the gapless case: no IDLE cycle and `sdo_o` never shows IDLE_LVL.
  - Otherwise go to IDLE.
- **`load_ready_o`:** equals (state==IDLE) | (count==1 & `en_i`). It is combinational from `en_i` and registered state.
- **Loads outside the ready window:** a load offered in SHIFT outside that window is not accepted, and the upstream holds it.
- **Status outputs:**
  - `busy_o` = (state==SHIFT).
  - `count_o` = count; it is 0 in IDLE.
- **Gaps in `en_i`:** gaps of any length between strobes are legal. State, register and count hold.
- **Reset mid-word:** the word is dropped, all outputs return to reset values asynchronously, and no `done_o` is produced.

## Timing
- **Load latency:** a load accepted in cycle N gives the first bit on `sdo_o`, `busy_o`=1 and `count_o`=WIDTH in cycle N+1.
- **Bit advance:** an `en_i` in cycle k presents the next bit in cycle k+1.
- **`done_o`:** high exactly in the cycle after the final `en_i`. In that cycle `busy_o`=0, unless a back-to-back load was taken.
- **Throughput:** with `en_i` held high continuously, one word every WIDTH cycles, and `done_o` pulses every WIDTH cycles.
- **Output path:** `sdo_o` is driven from registered state only, so it is glitch-free.

## Configuration
`PISO_PRESET_EN`:
- **Defined:**
  - Port `prst_i` exists. Its priority is below `rst_i` and above load and `en_i`.
  - When high at a clock edge: the register is set to all ones, count=WIDTH, state=SHIFT. The next cycle shows `sdo_o`=1 and `busy_o`=1.
  - Any in-flight word is aborted without a `done_o`.
  - A simultaneous load is not accepted: `load_ready_o` is forced to 0 while `prst_i` is high.
- **Not defined:** no `prst_i` port and no preset logic. The rest of the behaviour is unchanged.

## Test plan
- **MSB-first word, continuous strobe** (WIDTH=8, LSB_FIRST=0): load 0xA5, then `en_i` high for 8 cycles → `sdo_o`=1,0,1,0,0,1,0,1; `count_o` steps 8→1 then reaches 0; `done_o` is a single pulse the cycle after the 8th strobe; `sdo_o` then returns to IDLE_LVL.
- **LSB-first with idle high** (LSB_FIRST=1, IDLE_LVL=1): load 0x0F, `en_i` every 3rd cycle → `sdo_o`=1,1,1,1,0,0,0,0, each bit held 3 cycles; `sdo_o`=1 before the load and after `done_o`.
- **Back-to-back words:** load 0xFF, then hold 0x00 valid throughout → 0x00 is accepted on the 8th strobe cycle; `sdo_o` goes from the last 1 straight to the first 0; `busy_o` stays 1; `done_o` pulses once per word.
- **Stall on busy:** offer 0x3C while 0xA5 is at count=5 → `load_ready_o`=0 and 0xA5 is unaffected; 0x3C is accepted only at the final strobe.
- **Reset mid-word:** assert `rst_i` at count=4 → `sdo_o`=IDLE_LVL, `busy_o`=0, `count_o`=0, with no `done_o`; a fresh load of 0x81 then serializes correctly.
- **Preset** (`PISO_PRESET_EN` defined): pulse `prst_i` with 0x00 mid-word → next cycle `count_o`=8 and 8 ones shift out; `done_o` pulses only at the end of the preset word; a load offered during `prst_i` is not accepted.
